// File: rtl/instr_decode_queue.sv
// Instruction decode queue: decodes RV32 opcodes at enqueue and buffers the
// decoded entries in a small FIFO, with a saturating illegal-instruction counter.
module instr_decode_queue #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 2,
    parameter bit CSR_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [31:0]              instr_i,
    input  logic [WIDTH-1:0]         pc_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              instr_o,
    output logic [WIDTH-1:0]         pc_o,
    output logic                     reg_write_o,
    output logic                     alu_src_o,
    output logic                     mem_write_o,
    output logic                     width_op_o,
    output logic                     pc_base_src_o,
    output logic                     csr_we_o,
    output logic [2:0]               imm_src_o,
    output logic [2:0]               result_src_o,
    output logic [1:0]               alu_op_o,
    output logic [1:0]               branch_op_o,
    output logic                     illegal_o,
    output logic [CNT_W-1:0]         illegal_cnt_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_CSR    = 7'b1110011;

    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;
    localparam logic [2:0] IMM_J   = 3'b011;
    localparam logic [2:0] IMM_U   = 3'b100;
    localparam logic [2:0] IMM_CSR = 3'b101;

    localparam logic [2:0] RES_ALU      = 3'b000;
    localparam logic [2:0] RES_MEM      = 3'b001;
    localparam logic [2:0] RES_PC4      = 3'b010;
    localparam logic [2:0] RES_IMM      = 3'b011;
    localparam logic [2:0] RES_PCTARGET = 3'b100;
    localparam logic [2:0] RES_CSR      = 3'b101;

    localparam logic [1:0] BR_NON    = 2'b00;
    localparam logic [1:0] BR_BRANCH = 2'b01;
    localparam logic [1:0] BR_JUMP   = 2'b10;

    localparam logic [1:0] ALU_ADD     = 2'b00;
    localparam logic [1:0] ALU_SUB     = 2'b01;
    localparam logic [1:0] ALU_PROCESS = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic [2:0] imm_src;
        logic       alu_src;
        logic       mem_write;
        logic [2:0] result_src;
        logic [1:0] branch_op;
        logic [1:0] alu_op;
        logic       width_op;
        logic       pc_base_src;
        logic       csr_we;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic [31:0]      instr;
        logic [WIDTH-1:0] pc;
        ctrl_t            ctrl;
    } entry_t;

    // Unknown opcodes (and CSR when disabled) decode to all-zero controls plus illegal.
    function automatic ctrl_t decode(input logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_R: begin
                c.reg_write = 1'b1; c.imm_src = IMM_I; c.result_src = RES_ALU;
                c.branch_op = BR_NON; c.alu_op = ALU_PROCESS;
            end
            OP_I_ALU: begin
                c.reg_write = 1'b1; c.imm_src = IMM_I; c.alu_src = 1'b1;
                c.result_src = RES_ALU; c.alu_op = ALU_PROCESS;
            end
            OP_LOAD: begin
                c.reg_write = 1'b1; c.imm_src = IMM_I; c.alu_src = 1'b1;
                c.result_src = RES_MEM; c.alu_op = ALU_ADD; c.width_op = 1'b1;
            end
            OP_STORE: begin
                c.imm_src = IMM_S; c.alu_src = 1'b1; c.mem_write = 1'b1;
                c.result_src = RES_ALU; c.alu_op = ALU_ADD; c.width_op = 1'b1;
            end
            OP_BRANCH: begin
                c.imm_src = IMM_B; c.result_src = RES_ALU; c.branch_op = BR_BRANCH;
                c.alu_op = ALU_SUB; c.pc_base_src = 1'b0;
            end
            OP_JAL: begin
                c.reg_write = 1'b1; c.imm_src = IMM_J; c.result_src = RES_PC4;
                c.branch_op = BR_JUMP; c.alu_op = ALU_ADD; c.pc_base_src = 1'b0;
            end
            OP_JALR: begin
                c.reg_write = 1'b1; c.imm_src = IMM_I; c.result_src = RES_PC4;
                c.branch_op = BR_JUMP; c.alu_op = ALU_ADD; c.pc_base_src = 1'b1;
            end
            OP_LUI: begin
                c.reg_write = 1'b1; c.imm_src = IMM_U; c.result_src = RES_IMM;
                c.alu_op = ALU_ADD;
            end
            OP_AUIPC: begin
                c.reg_write = 1'b1; c.imm_src = IMM_U; c.result_src = RES_PCTARGET;
                c.alu_op = ALU_ADD; c.pc_base_src = 1'b0;
            end
            OP_CSR: begin
                if (CSR_EN) begin
                    c.reg_write = 1'b1; c.imm_src = IMM_CSR; c.result_src = RES_CSR;
                    c.alu_op = ALU_ADD; c.csr_we = 1'b1;
                end else begin
                    c.illegal = 1'b1;
                end
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    entry_t             mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic [CNT_W-1:0]   illegal_cnt_r;

    logic               in_ready_s;
    logic               out_valid_s;
    logic               enq_s;
    logic               deq_s;
    entry_t             new_entry_s;
    entry_t             head_s;

    assign in_ready_s  = (count_r < CW'(DEPTH));
    assign out_valid_s = (count_r != '0);
    assign enq_s       = in_valid_i && in_ready_s && !flush_i;
    assign deq_s       = out_valid_s && out_ready_i && !flush_i;

    // Build the decoded entry for the incoming instruction and mask the head when empty.
    always_comb begin
        new_entry_s       = '0;
        new_entry_s.instr = instr_i;
        new_entry_s.pc    = pc_i;
        new_entry_s.ctrl  = decode(instr_i[6:0]);
        if (out_valid_s) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = '0;
        end
    end

    // Entry storage; the write side is only ever a decoded snapshot taken at enqueue.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (enq_s) begin
            mem_r[wr_ptr_r] <= new_entry_s;
        end
    end

    // Pointers, occupancy and the illegal counter; reset overrides flush which overrides handshakes.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            illegal_cnt_r <= '0;
        end else if (flush_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
                if (head_s.ctrl.illegal && (illegal_cnt_r != {CNT_W{1'b1}})) begin
                    illegal_cnt_r <= illegal_cnt_r + CNT_W'(1);
                end
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign in_ready_o    = in_ready_s;
    assign out_valid_o   = out_valid_s;
    assign count_o       = count_r;
    assign illegal_cnt_o = illegal_cnt_r;
    assign instr_o       = head_s.instr;
    assign pc_o          = head_s.pc;
    assign reg_write_o   = head_s.ctrl.reg_write;
    assign imm_src_o     = head_s.ctrl.imm_src;
    assign alu_src_o     = head_s.ctrl.alu_src;
    assign mem_write_o   = head_s.ctrl.mem_write;
    assign result_src_o  = head_s.ctrl.result_src;
    assign branch_op_o   = head_s.ctrl.branch_op;
    assign alu_op_o      = head_s.ctrl.alu_op;
    assign width_op_o    = head_s.ctrl.width_op;
    assign pc_base_src_o = head_s.ctrl.pc_base_src;
    assign csr_we_o      = head_s.ctrl.csr_we;
    assign illegal_o     = head_s.ctrl.illegal;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Bench for instr_decode_queue: two instances (CSR enabled / CSR disabled with a
// 2-bit counter) share stimulus; a scoreboard queue predicts every head and count.
module tb_instr_decode_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, flush, in_valid, out_ready;
    logic [31:0]      instr;
    logic [WIDTH-1:0] pc;

    logic             in_ready_a, out_valid_a, reg_write_a, alu_src_a, mem_write_a;
    logic             width_op_a, pc_base_a, csr_we_a, illegal_a;
    logic [31:0]      instr_a;
    logic [WIDTH-1:0] pc_a;
    logic [2:0]       imm_src_a, result_src_a;
    logic [1:0]       alu_op_a, branch_op_a, count_a;
    logic [15:0]      icnt_a;

    logic             in_ready_b, out_valid_b, reg_write_b, alu_src_b, mem_write_b;
    logic             width_op_b, pc_base_b, csr_we_b, illegal_b;
    logic [31:0]      instr_b;
    logic [WIDTH-1:0] pc_b;
    logic [2:0]       imm_src_b, result_src_b;
    logic [1:0]       alu_op_b, branch_op_b, count_b;
    logic [1:0]       icnt_b;

    instr_decode_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CSR_EN(1'b1), .CNT_W(16)) u_dut_a (
        .clk_i(clk), .reset_i(reset), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready_a), .instr_i(instr), .pc_i(pc), .out_valid_o(out_valid_a),
        .out_ready_i(out_ready), .instr_o(instr_a), .pc_o(pc_a), .reg_write_o(reg_write_a),
        .alu_src_o(alu_src_a), .mem_write_o(mem_write_a), .width_op_o(width_op_a),
        .pc_base_src_o(pc_base_a), .csr_we_o(csr_we_a), .imm_src_o(imm_src_a),
        .result_src_o(result_src_a), .alu_op_o(alu_op_a), .branch_op_o(branch_op_a),
        .illegal_o(illegal_a), .illegal_cnt_o(icnt_a), .count_o(count_a)
    );

    instr_decode_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CSR_EN(1'b0), .CNT_W(2)) u_dut_b (
        .clk_i(clk), .reset_i(reset), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready_b), .instr_i(instr), .pc_i(pc), .out_valid_o(out_valid_b),
        .out_ready_i(out_ready), .instr_o(instr_b), .pc_o(pc_b), .reg_write_o(reg_write_b),
        .alu_src_o(alu_src_b), .mem_write_o(mem_write_b), .width_op_o(width_op_b),
        .pc_base_src_o(pc_base_b), .csr_we_o(csr_we_b), .imm_src_o(imm_src_b),
        .result_src_o(result_src_b), .alu_op_o(alu_op_b), .branch_op_o(branch_op_b),
        .illegal_o(illegal_b), .illegal_cnt_o(icnt_b), .count_o(count_b)
    );

    logic [16:0] head_a, head_b;
    assign head_a = {illegal_a, reg_write_a, imm_src_a, alu_src_a, mem_write_a, result_src_a,
                     branch_op_a, alu_op_a, width_op_a, pc_base_a, csr_we_a};
    assign head_b = {illegal_b, reg_write_b, imm_src_b, alu_src_b, mem_write_b, result_src_b,
                     branch_op_b, alu_op_b, width_op_b, pc_base_b, csr_we_b};

    typedef struct {
        logic [31:0]      instr;
        logic [WIDTH-1:0] pc;
    } stim_t;

    stim_t       sb[$];
    stim_t       stim_q[$];
    logic [15:0] exp_cnt_a;
    logic [1:0]  exp_cnt_b;
    int          check_cnt = 0;
    int          err_cnt = 0;
    logic [6:0]  ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011,
                              7'b1111111};

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Row layout {illegal, reg_write, imm, alu_src, mem_write, result, branch, alu_op, width, pc_base, csr_we}.
    function automatic logic [16:0] tb_decode(input logic [31:0] ins, input bit csr_en);
        case (ins[6:0])
            7'b0110011: return {1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0};
            7'b0010011: return {1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 3'b000, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0};
            7'b0000011: return {1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 3'b001, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
            7'b0100011: return {1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
            7'b1100011: return {1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 3'b000, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0};
            7'b1101111: return {1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 3'b010, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
            7'b1100111: return {1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b010, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0};
            7'b0110111: return {1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 3'b011, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
            7'b0010111: return {1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 3'b100, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
            7'b1110011: return csr_en ? {1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 3'b101, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1}
                                      : {1'b1, 16'h0000};
            default:    return {1'b1, 16'h0000};
        endcase
    endfunction

    function automatic stim_t mk(input logic [31:0] ins, input logic [WIDTH-1:0] addr);
        stim_t s;
        s.instr = ins;
        s.pc    = addr;
        return s;
    endfunction

    // One clock: compare all outputs against the model at negedge, then advance the model at posedge.
    task automatic step(output bit acc);
        bit          enq, deq;
        stim_t       h;
        logic [16:0] da, db;
        @(negedge clk);
        check_value("count_a", 64'(count_a), 64'(sb.size()));
        check_value("count_b", 64'(count_b), 64'(sb.size()));
        check_value("in_ready_a", 64'(in_ready_a), 64'(sb.size() < DEPTH));
        check_value("in_ready_b", 64'(in_ready_b), 64'(sb.size() < DEPTH));
        check_value("out_valid_a", 64'(out_valid_a), 64'(sb.size() > 0));
        check_value("out_valid_b", 64'(out_valid_b), 64'(sb.size() > 0));
        check_value("icnt_a", 64'(icnt_a), 64'(exp_cnt_a));
        check_value("icnt_b", 64'(icnt_b), 64'(exp_cnt_b));
        if (sb.size() > 0) begin
            h  = sb[0];
            da = tb_decode(h.instr, 1'b1);
            db = tb_decode(h.instr, 1'b0);
            check_value("head_instr_a", 64'(instr_a), 64'(h.instr));
            check_value("head_pc_a", 64'(pc_a), 64'(h.pc));
            check_value("head_ctrl_a", 64'(head_a), 64'(da));
            check_value("head_instr_b", 64'(instr_b), 64'(h.instr));
            check_value("head_pc_b", 64'(pc_b), 64'(h.pc));
            check_value("head_ctrl_b", 64'(head_b), 64'(db));
        end else begin
            check_value("empty_ip_a", {instr_a, pc_a}, 64'h0);
            check_value("empty_ctrl_a", 64'(head_a), 64'h0);
            check_value("empty_ip_b", {instr_b, pc_b}, 64'h0);
            check_value("empty_ctrl_b", 64'(head_b), 64'h0);
        end
        enq = in_valid && !flush && !reset && (sb.size() < DEPTH);
        deq = out_ready && !flush && !reset && (sb.size() > 0);
        @(posedge clk);
        if (reset) begin
            sb.delete();
            exp_cnt_a = 16'h0000;
            exp_cnt_b = 2'b00;
        end else if (flush) begin
            sb.delete();
        end else begin
            if (deq) begin
                h  = sb.pop_front();
                da = tb_decode(h.instr, 1'b1);
                db = tb_decode(h.instr, 1'b0);
                if (da[16] && exp_cnt_a != 16'hFFFF) exp_cnt_a = exp_cnt_a + 16'd1;
                if (db[16] && exp_cnt_b != 2'b11) exp_cnt_b = exp_cnt_b + 2'd1;
            end
            if (enq) sb.push_back(mk(instr, pc));
        end
        acc = enq;
        #1;
    endtask

    // Offer stim_q in order (held until accepted); rdy_mode 0=stall, 1=drain, 2=random.
    task automatic drive(input int cycles, input int rdy_mode, input int flush_pct);
        bit acc;
        for (int i = 0; i < cycles; i++) begin
            in_valid = (stim_q.size() > 0);
            if (stim_q.size() > 0) begin
                instr = stim_q[0].instr;
                pc    = stim_q[0].pc;
            end
            out_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            flush     = (flush_pct > 0) && ($urandom_range(0, 99) < flush_pct);
            step(acc);
            if (acc) void'(stim_q.pop_front());
        end
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        bit          acc;
        logic [31:0] r;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = 32'h0; pc = '0;
        exp_cnt_a = 16'h0000; exp_cnt_b = 2'b00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // LOAD into an empty queue appears on the head one cycle later
        stim_q.push_back(mk(32'h00000083, 32'h100));
        drive(1, 0, 0);
        check_value("load_valid", 64'(out_valid_a), 64'h1);
        check_value("load_fields", 64'({reg_write_a, imm_src_a, alu_src_a, result_src_a, alu_op_a, width_op_a}),
                    64'({1'b1, 3'b000, 1'b1, 3'b001, 2'b00, 1'b1}));
        check_value("load_pc", 64'(pc_a), 64'h100);
        drive(3, 1, 0);

        // Stall consumer and offer DEPTH+1, then release
        stim_q.push_back(mk(32'h00A00013, 32'h104));
        stim_q.push_back(mk(32'h00B12023, 32'h108));
        stim_q.push_back(mk(32'hFE000EE3, 32'h10C));
        drive(6, 0, 0);
        check_value("full_left", 64'(stim_q.size()), 64'd1);
        check_value("full_count", 64'(count_a), 64'(DEPTH));
        check_value("full_ready", 64'(in_ready_a), 64'h0);
        drive(10, 1, 0);
        check_value("drain_left", 64'(stim_q.size()), 64'd0);

        // CSR opcode: legal on instance A, illegal on instance B
        stim_q.push_back(mk(32'h00000073, 32'h200));
        drive(1, 0, 0);
        check_value("csr_a", 64'({csr_we_a, result_src_a, illegal_a}), 64'({1'b1, 3'b101, 1'b0}));
        check_value("csr_b", 64'(head_b), 64'h10000);
        drive(1, 1, 0);
        check_value("csr_cnt_b", 64'(icnt_b), 64'd1);
        check_value("csr_cnt_a", 64'(icnt_a), 64'd0);

        // Flush together with enqueue and dequeue at count 1
        stim_q.push_back(mk(32'h00000033, 32'h300));
        drive(1, 0, 0);
        in_valid = 1'b1; instr = 32'h00000013; pc = 32'h304; out_ready = 1'b1; flush = 1'b1;
        step(acc);
        flush = 1'b0; in_valid = 1'b0;
        check_value("flush_count", 64'(count_a), 64'd0);
        check_value("flush_valid", 64'(out_valid_a), 64'h0);
        check_value("flush_cnt_b", 64'(icnt_b), 64'd1);

        // Saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) stim_q.push_back(mk(32'h0000007F, 32'h400 + 32'(4 * i)));
        drive(14, 1, 0);
        check_value("sat_cnt_b", 64'(icnt_b), 64'd3);
        check_value("sat_cnt_a", 64'(icnt_a), 64'd5);

        // Random traffic with occasional flushes
        for (int i = 0; i < 150; i++) begin
            r      = $urandom();
            r[6:0] = ops[$urandom_range(0, 10)];
            stim_q.push_back(mk(r, $urandom()));
        end
        drive(400, 2, 3);
        stim_q.delete();
        drive(6, 1, 0);

        // Reset while full
        stim_q.push_back(mk(32'h00000037, 32'h500));
        stim_q.push_back(mk(32'h0000007F, 32'h504));
        stim_q.push_back(mk(32'h00000017, 32'h508));
        drive(3, 0, 0);
        check_value("prefull_count", 64'(count_a), 64'(DEPTH));
        reset = 1'b1;
        step(acc);
        reset = 1'b0;
        check_value("rst_count", 64'(count_a), 64'd0);
        check_value("rst_ready", 64'(in_ready_a), 64'h1);
        check_value("rst_cnt", 64'({icnt_a, icnt_b}), 64'h0);
        check_value("rst_head", {instr_a, pc_a}, 64'h0);
        check_value("rst_ctrl", 64'(head_a), 64'h0);
        stim_q.delete();
        drive(2, 1, 0);

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/instr_decode_queue.md
INSTR_DECODE_QUEUE -- requirements
Module: instr_decode_queue

Interface
REQ-001 The module SHALL take parameter WIDTH, default 32: width of pc_i and pc_o.
REQ-002 The module SHALL take parameter DEPTH, default 2: output queue entries, a power of two from 2 to 8.
REQ-003 The module SHALL take parameter CSR_EN, default 1: when 0, the CSR opcode is treated as illegal.
REQ-004 The module SHALL take parameter CNT_W, default 16: width of the illegal-instruction counter.
REQ-005 The module SHALL have these ports:
  clk_i  in  1  clock; all state on the rising edge
  reset_i  in  1  synchronous, active-high reset
  flush_i  in  1  discard all queued and incoming entries
  in_valid_i  in  1  instruction offered
  in_ready_o  out  1  queue can accept
  instr_i  in  32  instruction word
  pc_i  in  WIDTH  instruction address
  out_valid_o  out  1  head entry valid
  out_ready_i  in  1  consumer accepts head
  instr_o, pc_o  out  32, WIDTH  head instruction and address
  reg_write_o, alu_src_o, mem_write_o, width_op_o, pc_base_src_o, csr_we_o  out  1 each  head control bits
  imm_src_o, result_src_o  out  3 each  head selects
  alu_op_o, branch_op_o  out  2 each  head selects
  illegal_o  out  1  head opcode illegal
  illegal_cnt_o  out  CNT_W  saturating illegal count
  count_o  out  $clog2(DEPTH)+1  occupancy

Function
REQ-006 Encodings SHALL match the codebase control macros: imm_src I=000 S=001 B=010 J=011 U=100 CSR=101; result_src ALU=000 MEM=001 PC+4=010 IMM=011 PCTARGET=100 CSR=101; branch_op NON=00 BRANCH=01 JUMP=10; alu_op ADD=00 SUB=01 PROCESS=10; alu_src reg=0 imm=1; pc_base PC=0 SRCA=1; width_op const=0 process=1.
REQ-007 Decode table (op = instr_i[6:0]; {reg_write, imm, alu_src, mem_write, result, branch, alu_op, width, pc_base, csr_we}):
  0110011 R: 1,I,0,0,ALU,NON,PROCESS,0,0,0
  0010011 I-ALU: 1,I,1,0,ALU,NON,PROCESS,0,0,0
  0000011 LOAD: 1,I,1,0,MEM,NON,ADD,1,0,0
  0100011 STORE: 0,S,1,1,ALU,NON,ADD,1,0,0
  1100011 BRANCH: 0,B,0,0,ALU,BRANCH,SUB,0,PC,0
  1101111 JAL: 1,J,0,0,PC+4,JUMP,ADD,0,PC,0
  1100111 JALR: 1,I,0,0,PC+4,JUMP,ADD,0,SRCA,0
  0110111 LUI: 1,U,0,0,IMM,NON,ADD,0,0,0
  0010111 AUIPC: 1,U,0,0,PCTARGET,NON,ADD,0,PC,0
  1110011 CSR (CSR_EN=1 only): 1,CSR,0,0,CSR,NON,ADD,0,0,1
REQ-008 Any other op, or CSR op with CSR_EN=0, SHALL store all control bits 0 and illegal_o=1.
REQ-009 Decode SHALL occur at enqueue; the stored entry carries instr_i, pc_i, controls, illegal flag.
REQ-010 Enqueue SHALL occur when in_valid_i && in_ready_o && !flush_i; dequeue when out_valid_o && out_ready_i && !flush_i.
REQ-011 in_ready_o SHALL be 1 iff count_o < DEPTH; it SHALL NOT depend on out_ready_i.
REQ-012 out_valid_o SHALL be 1 iff count_o > 0; head outputs SHALL be registered state (no combinational path from instr_i).
REQ-013 Latency: an instruction enqueued at edge N into an empty queue SHALL appear on the head at cycle N+1.
REQ-014 Simultaneous enqueue and dequeue SHALL leave count_o unchanged, including at count_o = DEPTH only if in_ready_o was 1 (i.e. never at full).
REQ-015 Read/write pointers SHALL wrap modulo DEPTH; order SHALL be strictly FIFO.
REQ-016 While out_valid_o=1 and out_ready_i=0, head outputs SHALL remain stable.
REQ-017 flush_i SHALL set count_o to 0 at the next edge and drop any same-cycle enqueue and dequeue; illegal_cnt_o is unaffected.
REQ-018 illegal_cnt_o SHALL increment by 1 on each dequeue of an entry with illegal_o=1, saturating at 2^CNT_W-1.
REQ-019 Decoded fields of empty (out_valid_o=0) slots SHALL be driven 0 on the outputs.

Reset
REQ-020 reset_i sampled high SHALL clear pointers, count_o=0, illegal_cnt_o=0, out_valid_o=0, in_ready_o=1, all head outputs 0, overriding flush_i and handshakes.
REQ-021 Reset mid-stream SHALL discard all entries; no dequeue is counted on the reset edge.

Verification
REQ-022 Load 0x00000083 (LOAD) pc 0x100 into empty queue -> next cycle out_valid_o=1, reg_write=1, imm=000, alu_src=1, result=001, alu_op=00, width_op=1, pc_o=0x100.
REQ-023 Hold out_ready_i=0, offer DEPTH+1 instructions -> in_ready_o=0 after DEPTH accepted, count_o=DEPTH, head stable; then release -> order preserved.
REQ-024 Dequeue 0x00000073 with CSR_EN=0 -> illegal_o=1, all controls 0, illegal_cnt_o 0->1; with CSR_EN=1 -> csr_we_o=1, result=101, illegal_o=0.
REQ-025 count_o=1, assert in_valid_i, out_ready_i and flush_i together -> next cycle count_o=0, out_valid_o=0, illegal_cnt_o unchanged.
REQ-026 CNT_W=2, dequeue five illegal ops (e.g. 0x0000007F) -> illegal_cnt_o=3.
REQ-027 Full queue, assert reset_i one cycle -> count_o=0, in_ready_o=1, illegal_cnt_o=0, all head outputs 0.
